// File: rtl/grf_wb_writer.sv
// rtl/grf_wb_writer.sv - GRF write-port driver merging W-stage and long-latency writebacks
//
// Purpose: merges the in-order W-stage write and buffered long-latency results
// into one registered GRF write stream. It also keeps a 32-bit pending
// scoreboard so decode can stall reads of registers not yet written.
//
// Optional feature: define GRF_WB_TRACE_EN to print one trace line per GRF write.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   pipe_we/waddr/wdata/pc             W-stage write (never stalled)
//   rsv_valid/rsv_addr                 reserve a destination register
//   lat_valid/lat_ready/lat_waddr/     long-latency result handshake
//   lat_wdata/lat_pc
//   rd_addr1/2, rd_busy1/2             decode scoreboard lookups
//   fifo_count                         buffered result count
//   grf_we/waddr/wdata/pc              registered GRF write port
//   idle                               nothing buffered, reserved or being written
module grf_wb_writer #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_waddr,
  input  logic [31:0]      pipe_wdata,
  input  logic [31:0]      pipe_pc,
  input  logic             rsv_valid,
  input  logic [4:0]       rsv_addr,
  input  logic             lat_valid,
  output logic             lat_ready,
  input  logic [4:0]       lat_waddr,
  input  logic [31:0]      lat_wdata,
  input  logic [31:0]      lat_pc,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  output logic             rd_busy1,
  output logic             rd_busy2,
  output logic [CNT_W-1:0] fifo_count,
  output logic             grf_we,
  output logic [4:0]       grf_waddr,
  output logic [31:0]      grf_wdata,
  output logic [31:0]      grf_pc,
  output logic             idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending;
  logic [31:0]      pending_next;

  logic             pipe_sel;
  logic             pop;
  logic             push;
  logic [4:0]       head_addr;
  logic [31:0]      head_data;
  logic [31:0]      head_pc;

  // Ready depends only on the current count: a full FIFO refuses a result
  // even in a cycle where it pops, which keeps this path free of pop logic.
  assign lat_ready = !reset && (count < FULL_CNT);

  // Writes to $0 from the pipe are dropped and leave the slot free for a pop.
  assign pipe_sel = pipe_we && (pipe_waddr != 5'd0);
  assign pop      = !pipe_sel && (count != '0);
  // A result for $0 completes the handshake but is never stored.
  assign push     = lat_valid && lat_ready && (lat_waddr != 5'd0);

  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign head_pc   = q_pc[rd_ptr];

  // Set is applied after clear so a same-cycle reservation wins.
  always_comb begin
    pending_next = pending;
    if (pop) begin
      pending_next[head_addr] = 1'b0;
    end
    if (rsv_valid) begin
      pending_next[rsv_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= lat_waddr;
      q_data[wr_ptr] <= lat_wdata;
      q_pc[wr_ptr]   <= lat_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      grf_we    <= 1'b0;
      grf_waddr <= 5'd0;
      grf_wdata <= 32'd0;
      grf_pc    <= 32'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      pending <= pending_next;

      if (pipe_sel) begin
        grf_we    <= 1'b1;
        grf_waddr <= pipe_waddr;
        grf_wdata <= pipe_wdata;
        grf_pc    <= pipe_pc;
      end else if (pop) begin
        grf_we    <= 1'b1;
        grf_waddr <= head_addr;
        grf_wdata <= head_data;
        grf_pc    <= head_pc;
      end else begin
        grf_we    <= 1'b0;
        grf_waddr <= 5'd0;
        grf_wdata <= 32'd0;
        grf_pc    <= 32'd0;
      end
    end
  end

  assign rd_busy1   = pending[rd_addr1] && (rd_addr1 != 5'd0);
  assign rd_busy2   = pending[rd_addr2] && (rd_addr2 != 5'd0);
  assign fifo_count = count;
  assign idle       = (count == '0) && (pending == 32'd0) && !grf_we;

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (!reset && pipe_sel) begin
      $display("%d@%h: $%d <= %h", $time, pipe_pc, pipe_waddr, pipe_wdata);
    end else if (!reset && pop) begin
      $display("%d@%h: $%d <= %h", $time, head_pc, head_addr, head_data);
    end
  end
`else
`endif

endmodule

// File: doc/grf_wb_writer.md
Name: grf_wb_writer

Overview:
- Write-side driver for the general register file (GRF) write port.
- Merges two writeback sources into one registered GRF write stream:
  - the in-order pipeline W stage;
  - long-latency results (MDU moves, slow bus loads) that arrive through a valid/ready handshake.
- Tracks registers reserved by in-flight long-latency ops, so decode can stall reads of values not yet written.

Parameters:
DEPTH, 4, long-latency result FIFO entries; power of 2, minimum 2.
CNT_W, $clog2(DEPTH)+1, width of fifo_count (derived, not overridden).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pipe_we  input  1  W-stage write enable
pipe_waddr  input  5  W-stage destination register
pipe_wdata  input  32  W-stage write data
pipe_pc  input  32  W-stage instruction PC
rsv_valid  input  1  long-latency op issued this cycle; reserve rsv_addr
rsv_addr  input  5  reserved destination register
lat_valid  input  1  long-latency result valid
lat_ready  output  1  FIFO can accept a result
lat_waddr  input  5  result destination register
lat_wdata  input  32  result data
lat_pc  input  32  PC of producing instruction
rd_addr1  input  5  decode read address 1
rd_addr2  input  5  decode read address 2
rd_busy1  output  1  rd_addr1 reserved, not yet written
rd_busy2  output  1  rd_addr2 reserved, not yet written
fifo_count  output  CNT_W  entries currently buffered
grf_we  output  1  GRF write enable (registered)
grf_waddr  output  5  GRF write address (registered)
grf_wdata  output  32  GRF write data (registered)
grf_pc  output  32  PC for GRF trace (registered)
idle  output  1  nothing buffered, reserved or being written

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset:
  - FIFO emptied, all pending bits cleared.
  - grf_we/grf_waddr/grf_wdata/grf_pc = 0.
  - lat_ready = 0 during the reset cycle, 1 afterwards.
- Per-cycle output-slot arbitration, registered into grf_* at the next posedge:
  1. If pipe_we && pipe_waddr != 0: output the pipe write. The pipeline is never stalled.
  2. Else, if FIFO is non-empty: pop the head, output it, and clear pending[head.waddr].
  3. Else: grf_we = 0; grf_waddr/grf_wdata/grf_pc = 0.
- pipe_we with pipe_waddr = 0: dropped; the slot counts as free for a FIFO pop.
- FIFO push:
  - Push when lat_valid && lat_ready.
  - lat_ready = (fifo_count < DEPTH), purely from the current count, with no same-cycle pop credit. A full FIFO therefore stalls the producer for one cycle even if it pops that cycle.
  - lat_waddr = 0: handshake completes, nothing stored, no GRF write.
- FIFO latency and bypass:
  - No bypass. A result accepted at edge N is popped at edge N+1 at the earliest, so grf_we is high during cycle N+1..N+2, i.e. minimum 2 cycles.
  - Push into an empty FIFO and pop in the same cycle cannot occur.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Ordering:
  - FIFO drains strictly in arrival order.
  - Decode stalls on busy registers, so any pipe write to a reserved register belongs to an older instruction. Pipe-first priority therefore preserves program order; no extra check is required.
- Scoreboard (32 pending bits, bit 0 hard-wired to 0):
  - rsv_valid sets pending[rsv_addr].
  - Popping a FIFO entry clears pending[waddr].
  - Set and clear of the same register in the same cycle: set wins.
  - Re-reserving an already-pending register leaves the bit set; it is cleared on the next matching pop.
- rd_busyN = pending[rd_addrN] && rd_addrN != 0. Combinational from registered state; no forwarding of same-cycle rsv_valid.
- idle = (fifo_count == 0) && (pending == 0) && !grf_we.

Optional Feature:
- Macro: GRF_WB_TRACE_EN.
- Defined: on every posedge where grf_we is being asserted (the slot is filled, reset low), emit $display("%d@%h: $%d <= %h", $time, pc, waddr, wdata) for the selected write, one line per write.
- Undefined: no simulation output; RTL otherwise identical.

Test Plan:
- Reset then idle: hold reset 2 cycles, release, inputs 0 → grf_we=0, lat_ready=1, fifo_count=0, idle=1.
- Pipe write: pipe_we=1, waddr=5, wdata=0x1234, pc=0x3000 at edge N → grf_we=1, waddr=5, wdata=0x1234, grf_pc=0x3000 after edge N; with waddr=0 → grf_we stays 0.
- Reservation and busy:
  - rsv_valid at $8 → rd_busy1=1 for rd_addr1=8 from the next cycle.
  - lat result $8=0xCAFE → grf_we with 0xCAFE two cycles after acceptance; rd_busy1=0 the cycle after that write.
- Priority and ordering: FIFO holds $9=0xA then $10=0xB; pipe writes $3 for 2 consecutive cycles → $3, $3, $9, $10 in that order on grf_*; fifo_count 2,2,1,0.
- Full FIFO (DEPTH=4): push 4 results with pipe busy writing → lat_ready=0, fifo_count=4, fifth lat_valid held; pipe goes idle → pop, lat_ready=1 next cycle, fifth accepted, no data lost.
- Reset mid-operation: FIFO count 3, pending {$4,$6} set, assert reset → next cycle fifo_count=0, rd_busy=0 for all registers, grf_we=0; the buffered entries are never written.
